// File: rtl/jedro_1_tohost_pkg.sv
// ============================================================================
// Module      : jedro_1_tohost_pkg
// Description : Shared constants and helpers for the tohost device slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package jedro_1_tohost_pkg;

  localparam logic [31:0] c_base_addr_default = 32'hFFFF_FFF0;

  // Word offsets within the 16-byte window (addr[3:2])
  localparam logic [1:0] c_off_halt      = 2'd0;
  localparam logic [1:0] c_off_sig_start = 2'd1;
  localparam logic [1:0] c_off_sig_end   = 2'd2;
  localparam logic [1:0] c_off_console   = 2'd3;

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_resp  = 2'd1;
  localparam logic [1:0] c_st_stall = 2'd2;

  function automatic logic [31:0] apply_be(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/jedro_1_sync_fifo.sv
// ============================================================================
// Module      : jedro_1_sync_fifo
// Description : Single-clock FIFO with occupancy count; push/pop may coincide.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jedro_1_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full_o    = (r_count == (AW+1)'(DEPTH));
  assign empty_o   = (r_count == '0);
  assign count_o   = r_count;
  assign rdata_o   = r_mem[r_rd_ptr];
  assign w_do_push = push_i && !full_o;
  assign w_do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (w_do_push) r_mem[r_wr_ptr] <= wdata_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/jedro_1_tohost_dev.sv
// ============================================================================
// Module      : jedro_1_tohost_dev
// Description : Memory-mapped halt/signature/console device with stalling writes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jedro_1_tohost_dev
  import jedro_1_tohost_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = c_base_addr_default,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        stb_i,
  input  logic [3:0]  we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ack_o,
  output logic        err_o,
  output logic        halt_o,
  output logic [31:0] sig_start_o,
  output logic [31:0] sig_end_o,
  output logic        cons_valid_o,
  output logic [7:0]  cons_data_o,
  input  logic        cons_ready_i
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]    r_state;
  logic          r_halt;
  logic [31:0]   r_sig_start;
  logic [31:0]   r_sig_end;
  logic [31:0]   r_rdata;
  logic          r_ack;
  logic          r_err;
  logic [7:0]    r_pend;

  logic          w_addr_ok;
  logic          w_is_wr;
  logic [1:0]    w_off;
  logic          w_bad;
  logic          w_push;
  logic [7:0]    w_push_data;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [31:0]   w_rd_val;

  assign w_addr_ok = (addr_i[31:4] == BASE_ADDR[31:4]) && (addr_i[1:0] == 2'b00);
  assign w_is_wr   = |we_i;
  assign w_off     = addr_i[3:2];
  assign w_bad     = !w_addr_ok || (w_is_wr && (w_off == c_off_console) && !we_i[0]);

  // Fullness is the registered count: a pop in the same cycle never lets a push in
  assign w_push = ((r_state == c_st_idle) && stb_i && !w_bad && w_is_wr &&
                   (w_off == c_off_console) && !w_full) ||
                  ((r_state == c_st_stall) && !w_full);
  assign w_push_data = (r_state == c_st_stall) ? r_pend : wdata_i[7:0];
  assign w_pop       = cons_valid_o && cons_ready_i;

  always_comb begin
    w_rd_val = '0;
    case (w_off)
      c_off_halt:      w_rd_val = {31'b0, r_halt};
      c_off_sig_start: w_rd_val = r_sig_start;
      c_off_sig_end:   w_rd_val = r_sig_end;
      default:         w_rd_val = 32'(w_count);
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_state     <= c_st_idle;
      r_halt      <= 1'b0;
      r_sig_start <= '0;
      r_sig_end   <= '0;
      r_rdata     <= '0;
      r_ack       <= 1'b0;
      r_err       <= 1'b0;
      r_pend      <= '0;
    end else begin
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
      case (r_state)
        c_st_idle: begin
          if (stb_i) begin
            if (w_bad) begin
              r_err   <= 1'b1;
              r_state <= c_st_resp;
            end else if (w_is_wr) begin
              case (w_off)
                c_off_halt:      if (we_i[0] && wdata_i[0]) r_halt <= 1'b1;
                c_off_sig_start: r_sig_start <= apply_be(r_sig_start, wdata_i, we_i);
                c_off_sig_end:   r_sig_end   <= apply_be(r_sig_end, wdata_i, we_i);
                default:         r_pend      <= wdata_i[7:0];
              endcase
              if ((w_off == c_off_console) && w_full) begin
                r_state <= c_st_stall;
              end else begin
                r_ack   <= 1'b1;
                r_state <= c_st_resp;
              end
            end else begin
              r_ack   <= 1'b1;
              r_rdata <= w_rd_val;
              r_state <= c_st_resp;
            end
          end
        end
        c_st_resp: r_state <= c_st_idle;
        c_st_stall: begin
          if (!w_full) begin
            r_ack   <= 1'b1;
            r_state <= c_st_resp;
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  jedro_1_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (w_push),
    .wdata_i (w_push_data),
    .pop_i   (w_pop),
    .rdata_o (cons_data_o),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count)
  );

  assign cons_valid_o = !w_empty;
  assign rdata_o      = r_rdata;
  assign ack_o        = r_ack;
  assign err_o        = r_err;
  assign halt_o       = r_halt;
  assign sig_start_o  = r_sig_start;
  assign sig_end_o    = r_sig_end;

endmodule

`default_nettype wire

// File: tb/tb_jedro_1_tohost_dev.sv
// ============================================================================
// Module      : tb_jedro_1_tohost_dev
// Description : Directed self-checking bench for the tohost device.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jedro_1_tohost_dev;

  localparam logic [31:0] A_HALT  = 32'hFFFF_FFF0;
  localparam logic [31:0] A_SIGS  = 32'hFFFF_FFF4;
  localparam logic [31:0] A_SIGE  = 32'hFFFF_FFF8;
  localparam logic [31:0] A_CONS  = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        stb = 1'b0;
  logic [3:0]  we = 4'h0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        ack, err, halt;
  logic [31:0] sig_start, sig_end;
  logic        cons_valid;
  logic [7:0]  cons_data;
  logic        cons_ready = 1'b0;

  logic        got_ack, got_err;
  logic [31:0] got_rdata;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  jedro_1_tohost_dev dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .stb_i        (stb),
    .we_i         (we),
    .addr_i       (addr),
    .wdata_i      (wdata),
    .rdata_o      (rdata),
    .ack_o        (ack),
    .err_o        (err),
    .halt_o       (halt),
    .sig_start_o  (sig_start),
    .sig_end_o    (sig_end),
    .cons_valid_o (cons_valid),
    .cons_data_o  (cons_data),
    .cons_ready_i (cons_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Strobe for one cycle, then sample the response one cycle later
  task automatic do_req(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    stb = 1'b1; we = w; addr = a; wdata = d;
    @(negedge clk);
    stb = 1'b0; we = 4'h0; addr = '0; wdata = '0;
    got_ack = ack; got_err = err; got_rdata = rdata;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    logic [7:0] exp_bytes [9];
    int k;
    int ack_iter;
    int ack_cnt;
    int err_cnt;

    for (int i = 0; i < 9; i++) exp_bytes[i] = 8'h41 + 8'(i);

    // Reset state
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_halt", 32'(halt), 32'h0);
    check("rst_sig_start", sig_start, 32'h0);
    check("rst_sig_end", sig_end, 32'h0);
    check("rst_cons_valid", 32'(cons_valid), 32'h0);

    // Signature start write and read-back
    do_req(4'hF, A_SIGS, 32'h8000_2000);
    check("sigs_wr_ack", 32'(got_ack), 32'h1);
    check("sigs_wr_err", 32'(got_err), 32'h0);
    check("sigs_value", sig_start, 32'h8000_2000);
    do_req(4'h0, A_SIGS, 32'h0);
    check("sigs_rd_ack", 32'(got_ack), 32'h1);
    check("sigs_rd_data", got_rdata, 32'h8000_2000);
    @(negedge clk);
    check("rdata_idle_zero", rdata, 32'h0);

    // Halt is sticky
    do_req(4'hF, A_HALT, 32'h1);
    check("halt_set_ack", 32'(got_ack), 32'h1);
    check("halt_set", 32'(halt), 32'h1);
    do_req(4'hF, A_HALT, 32'h0);
    check("halt_sticky", 32'(halt), 32'h1);
    do_req(4'h0, A_HALT, 32'h0);
    check("halt_rd", got_rdata, 32'h1);

    // Address errors leave registers alone
    do_req(4'hF, 32'h0000_0000, 32'h1234_5678);
    check("oob_err", 32'(got_err), 32'h1);
    check("oob_ack", 32'(got_ack), 32'h0);
    check("oob_rdata", got_rdata, 32'h0);
    do_req(4'hF, 32'hFFFF_FFF2, 32'h1234_5678);
    check("misalign_err", 32'(got_err), 32'h1);
    check("err_sig_start", sig_start, 32'h8000_2000);
    check("err_sig_end", sig_end, 32'h0);
    do_req(4'b0010, A_CONS, 32'h0000_4100);
    check("cons_be_err", 32'(got_err), 32'h1);
    check("cons_be_nopush", 32'(cons_valid), 32'h0);

    // Byte-lane write on signature end
    do_req(4'hF, A_SIGE, 32'hFFFF_FFFF);
    do_req(4'b0100, A_SIGE, 32'h0012_0000);
    check("sige_bytelane", sig_end, 32'hFF12_FFFF);
    do_req(4'h0, A_SIGE, 32'h0);
    check("sige_rd", got_rdata, 32'hFF12_FFFF);

    // Reset clears halt and signature registers
    pulse_reset();
    check("rst2_halt", 32'(halt), 32'h0);
    check("rst2_sig_start", sig_start, 32'h0);
    check("rst2_sig_end", sig_end, 32'h0);

    // Fill console FIFO, ninth write stalls
    cons_ready = 1'b0;
    ack_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      do_req(4'h1, A_CONS, 32'(exp_bytes[i]));
      if (got_ack === 1'b1 && got_err === 1'b0) ack_cnt++;
    end
    check("cons_fill_acks", 32'(ack_cnt), 32'd8);
    do_req(4'h0, A_CONS, 32'h0);
    check("cons_count_full", got_rdata, 32'd8);
    check("cons_head", 32'(cons_data), 32'h41);
    do_req(4'h1, A_CONS, 32'(exp_bytes[8]));
    check("stall_no_ack", 32'(got_ack), 32'h0);
    check("stall_no_err", 32'(got_err), 32'h0);
    repeat (3) @(negedge clk);
    check("stall_hold_ack", 32'(ack), 32'h0);

    // Drain: bytes in order, stalled write acked two cycles after first pop
    cons_ready = 1'b1;
    k = 0;
    ack_iter = -1;
    err_cnt = 0;
    for (int it = 0; it < 40 && k < 9; it++) begin
      if (ack === 1'b1 && ack_iter < 0) ack_iter = it;
      if (err === 1'b1) err_cnt++;
      if (cons_valid === 1'b1) begin
        check("drain_byte", 32'(cons_data), 32'(exp_bytes[k]));
        k++;
      end
      @(negedge clk);
    end
    check("drain_count", 32'(k), 32'd9);
    check("stall_ack_cycle", 32'(ack_iter), 32'd2);
    check("drain_no_err", 32'(err_cnt), 32'd0);
    check("drain_empty", 32'(cons_valid), 32'h0);
    cons_ready = 1'b0;

    // Reset while stalled drops the request
    for (int i = 0; i < 8; i++) do_req(4'h1, A_CONS, 32'h60 + 32'(i));
    do_req(4'h1, A_CONS, 32'h70);
    check("stall2_no_ack", 32'(got_ack), 32'h0);
    pulse_reset();
    ack_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (ack !== 1'b0 || err !== 1'b0) ack_cnt++;
      @(negedge clk);
    end
    check("rst_stall_no_resp", 32'(ack_cnt), 32'd0);
    check("rst_stall_empty", 32'(cons_valid), 32'h0);
    do_req(4'h0, A_CONS, 32'h0);
    check("rst_stall_count", got_rdata, 32'h0);
    check("rst_stall_rd_ack", 32'(got_ack), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/jedro_1_tohost_dev.md
JEDRO_1_TOHOST_DEV -- requirements
Module: jedro_1_tohost_dev

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'hFFFF_FFF0, byte base of the 16-byte register window (bits [3:0] zero).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, console FIFO entries (power of two, >=2).
REQ-003 SHALL have port clk_i input 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rstn_i input 1: reset, synchronous, active-low.
REQ-005 SHALL have port stb_i input 1: request strobe; one cycle per request.
REQ-006 SHALL have port we_i input 4: byte write enables; 4'b0000 means read.
REQ-007 SHALL have port addr_i input 32: byte address.
REQ-008 SHALL have port wdata_i input 32: write data.
REQ-009 SHALL have port rdata_o output 32: read data, valid while ack_o is high.
REQ-010 SHALL have port ack_o output 1: one-cycle successful completion.
REQ-011 SHALL have port err_o output 1: one-cycle failed completion.
REQ-012 SHALL have port halt_o output 1: sticky halt flag.
REQ-013 SHALL have ports sig_start_o and sig_end_o, output 32 each: signature region bounds.
REQ-014 SHALL have ports cons_valid_o output 1, cons_data_o output 8, cons_ready_i input 1: console byte stream.

Function
REQ-015 Map by offset addr_i[3:2]: 0 HALT, 1 SIG_START, 2 SIG_END, 3 CONSOLE.
REQ-016 addr_i[31:4] != BASE_ADDR[31:4], or addr_i[1:0] != 0 -> err_o one cycle after stb_i; no state change.
REQ-017 FSM states IDLE, RESP, STALL; IDLE->RESP on stb_i unless stalled; RESP->IDLE always; STALL->RESP when FIFO count < FIFO_DEPTH.
REQ-018 Non-stalled requests: exactly one of ack_o/err_o high in cycle N+1 for stb_i in cycle N.
REQ-019 stb_i while not in IDLE is a protocol violation; ignored, no response.
REQ-020 HALT write with we_i[0] and wdata_i[0]=1 sets halt_o; cleared only by reset; writing 0 has no effect.
REQ-021 SIG_START/SIG_END writes update only bytes whose we_i bit is set.
REQ-022 Reads: HALT -> {31'b0,halt_o}; SIG_* -> register; CONSOLE -> zero-extended FIFO count.
REQ-023 CONSOLE write requires we_i[0]; else err_o; pushes wdata_i[7:0].
REQ-024 CONSOLE write when count = FIFO_DEPTH -> STALL; push in first cycle count < FIFO_DEPTH (registered count; same-cycle pop not considered); ack_o next cycle.
REQ-025 cons_valid_o = FIFO not empty; cons_data_o = head; pop when cons_valid_o & cons_ready_i.
REQ-026 Simultaneous push and pop: count unchanged, order preserved.
REQ-027 Writes after halt_o accepted normally.
REQ-028 rdata_o SHALL be 0 when ack_o is low.

Reset
REQ-029 rstn_i low at a clock edge: FSM IDLE, FIFO emptied, halt_o=0, sig_start_o=0, sig_end_o=0, ack_o=0, err_o=0, rdata_o=0, cons_valid_o=0.
REQ-030 Reset mid-request (RESP or STALL) drops the request; no ack_o/err_o emitted.

Structure
REQ-031 Register offsets, FSM state enum and BASE_ADDR default SHALL live in shared package jedro_1_tohost_pkg.
REQ-032 Console FIFO SHALL be sub-module jedro_1_sync_fifo (push/pop/full/empty/count, same clock/reset).

Verification
REQ-033 Write 0x8000_2000 to SIG_START with we_i=4'hF -> ack_o at N+1, sig_start_o=0x8000_2000; read back -> rdata_o=0x8000_2000.
REQ-034 Write 0x0000_0001 to HALT -> halt_o=1; write 0 -> halt_o stays 1; rstn_i low one cycle -> halt_o=0.
REQ-035 cons_ready_i=0, nine CONSOLE writes 0x41..0x49 -> first eight ack at N+1, ninth stalls; cons_ready_i=1 -> bytes 0x41..0x49 emerge in order, ninth acked after first pop.
REQ-036 Access to BASE_ADDR+0x10 and BASE_ADDR+0x2 -> err_o at N+1, registers unchanged; CONSOLE write with we_i=4'b0010 -> err_o.
REQ-037 Write SIG_END=0xFFFF_FFFF then we_i=4'b0100, wdata_i=0x0012_0000 -> sig_end_o=0xFF12_FFFF.
REQ-038 Reset asserted during STALL -> no ack_o/err_o, FIFO count read 0 afterwards.
